// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and types for the mux scan sampler
package mux_scan_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} scan_state_t;
    typedef logic [NCH-1:0] ch_mask_t;
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: finds the next enabled channel above sel, or the lowest enabled one when from_idle
module mux_scan_next_ch (
    input  logic [3:0] mask,
    input  logic [1:0] sel,
    input  logic       from_idle,
    output logic       found,
    output logic [1:0] next_sel
);
    import mux_scan_pkg::*;
    // descending walk so the lowest qualifying channel is the last one written
    always_comb begin
        found    = 1'b0;
        next_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (from_idle || i > int'(sel))) begin
                found    = 1'b1;
                next_sel = SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps a 4:1 mux select over enabled channels, samples z and hands off a result word
module mux_scan_sampler #(
    parameter int SETTLE   = 2,
    parameter int SETTLE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    input  logic       z,
    output logic       busy,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       start_err
);
    import mux_scan_pkg::*;

    scan_state_t         state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    ch_mask_t            m_q, m_d;
    ch_mask_t            shadow_q, shadow_d;
    ch_mask_t            word_q, word_d;
    logic                start_err_q, start_err_d;
    ch_mask_t            shadow_smp;
    logic                start_ok, last, found;
    logic [SEL_W-1:0]    next_sel;

    // an accepted start reuses the lookup to find the first channel of the new mask
    assign start_ok = start && (state_q == IDLE || (state_q == DONE && word_ready));
    assign last     = cnt_q == SETTLE_W'(SETTLE - 1);

    mux_scan_next_ch u_next (
        .mask      (start_ok ? mask : m_q),
        .sel       (sel_q),
        .from_idle (start_ok),
        .found     (found),
        .next_sel  (next_sel)
    );

    // next-state, channel stepping and result assembly
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        shadow_d    = shadow_q;
        word_d      = word_q;
        shadow_smp  = shadow_q;
        shadow_smp[sel_q] = z;
        start_err_d = start && (state_q == mux_scan_pkg::SETTLE || (state_q == DONE && !word_ready));
        if (start_ok) begin
            m_d      = mask;
            shadow_d = '0;
            cnt_d    = '0;
            sel_d    = found ? next_sel : '0;
            state_d  = found ? mux_scan_pkg::SETTLE : DONE;
            word_d   = found ? word_q : '0;
        end else if (state_q == mux_scan_pkg::SETTLE) begin
            cnt_d = last ? '0 : cnt_q + SETTLE_W'(1);
            if (last) begin
                shadow_d = shadow_smp;
                sel_d    = found ? next_sel : sel_q;
                state_d  = found ? mux_scan_pkg::SETTLE : DONE;
                word_d   = found ? word_q : shadow_smp;
            end
        end else if (state_q == DONE && word_ready) begin
            state_d = IDLE;
            sel_d   = '0;
        end
    end

    // state and datapath registers; reset discards any partial scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            m_q         <= '0;
            shadow_q    <= '0;
            word_q      <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            shadow_q    <= shadow_d;
            word_q      <= word_d;
            start_err_q <= start_err_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = state_q == mux_scan_pkg::SETTLE;
    assign word       = word_q;
    assign word_valid = state_q == DONE;
    assign start_err  = start_err_q;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb_mux_scan_sampler: directed scans against a 4:1 mux model with a scoreboard of expected words
module tb_mux_scan_sampler;
    localparam int SETTLE = 2;

    typedef struct {
        logic [3:0] word;
        int         lat;
        int         k;
        logic [7:0] chs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] mask = '0;
    logic [3:0] c = '0;
    logic       word_ready = 1'b0;
    logic [1:0] sel;
    logic       z, busy, word_valid, start_err;
    logic [3:0] word;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       sb[$];

    assign z = c[sel];

    always #5 clk = ~clk;

    mux_scan_sampler #(.SETTLE(SETTLE), .SETTLE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mask       (mask),
        .sel        (sel),
        .z          (z),
        .busy       (busy),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .start_err  (start_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drives a start for one cycle; returns #1 after the edge that samples it
    task automatic start_scan(input logic [3:0] m, input logic [3:0] cv, input bit push);
        exp_t e;
        mask  = m;
        c     = cv;
        start = 1'b1;
        e.word = cv & m;
        e.k    = 0;
        e.chs  = '0;
        for (int i = 0; i < 4; i++)
            if (m[i]) begin
                e.chs[2*e.k +: 2] = 2'(i);
                e.k++;
            end
        e.lat = e.k * SETTLE;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // follows the scan cycle by cycle, optionally pulsing an illegal start at cycle err_at
    task automatic wait_word(input int err_at);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        if (e.k == 0) check("sel_empty", {6'd0, sel}, 8'd0);
        while (!word_valid && n < 200) begin
            if (n / SETTLE < e.k) begin
                check("sel_step", {6'd0, sel}, {6'd0, e.chs[2*(n/SETTLE) +: 2]});
                check("busy", {7'd0, busy}, 8'd1);
            end
            if (n == err_at) begin
                start = 1'b1;
                mask  = 4'h0;
            end
            @(posedge clk); #1;
            n++;
            if (n - 1 == err_at) begin
                start = 1'b0;
                check("start_err_scan", {7'd0, start_err}, 8'd1);
            end
        end
        check("latency", n[7:0], e.lat[7:0]);
        check("word", {4'd0, word}, {4'd0, e.word});
        check("valid_hi", {7'd0, word_valid}, 8'd1);
    endtask

    task automatic handshake(input logic [3:0] w);
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        check("valid_drop", {7'd0, word_valid}, 8'd0);
        check("idle_busy", {7'd0, busy}, 8'd0);
        check("idle_sel", {6'd0, sel}, 8'd0);
        check("word_held", {4'd0, word}, {4'd0, w});
    endtask

    // directed sequence
    initial begin
        #1;
        check("rst_sel", {6'd0, sel}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_word", {4'd0, word}, 8'd0);
        check("rst_valid", {7'd0, word_valid}, 8'd0);
        check("rst_err", {7'd0, start_err}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        start_scan(4'hF, 4'b1010, 1);
        wait_word(-1);
        handshake(4'b1010);

        start_scan(4'b0101, 4'b1111, 1);
        wait_word(-1);
        handshake(4'b0101);

        start_scan(4'h0, 4'b1111, 1);
        wait_word(-1);
        handshake(4'h0);

        start_scan(4'hF, 4'b0110, 1);
        wait_word(3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_valid", {7'd0, word_valid}, 8'd1);
            check("hold_word", {4'd0, word}, 8'h06);
            check("start_err_done", {7'd0, start_err}, {7'd0, i == 2});
        end
        handshake(4'b0110);

        start_scan(4'b0011, 4'b0001, 1);
        wait_word(-1);
        word_ready = 1'b1;
        start_scan(4'h8, 4'b1000, 1);
        word_ready = 1'b0;
        check("b2b_valid", {7'd0, word_valid}, 8'd0);
        check("b2b_sel", {6'd0, sel}, 8'd3);
        check("b2b_busy", {7'd0, busy}, 8'd1);
        check("b2b_word_old", {4'd0, word}, 8'h01);
        wait_word(-1);
        handshake(4'b1000);

        start_scan(4'hF, 4'hF, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("third_ch", {6'd0, sel}, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", {6'd0, sel}, 8'd0);
        check("arst_busy", {7'd0, busy}, 8'd0);
        check("arst_word", {4'd0, word}, 8'd0);
        check("arst_valid", {7'd0, word_valid}, 8'd0);
        check("arst_err", {7'd0, start_err}, 8'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_valid", {7'd0, word_valid}, 8'd0);
            check("post_rst_busy", {7'd0, busy}, 8'd0);
        end
        start_scan(4'b1010, 4'b1111, 1);
        wait_word(-1);
        handshake(4'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
